// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg : shared types and constants for the UART receive path (rev 1.0) ====
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ==== sync_2ff : two-flop synchronizer with selectable reset value (rev 1.0) ====
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ==== uart_rx_8n1 : 8N1 UART receiver, mid-bit sampling, valid/ack handshake (rev 1.0) ====
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] C_HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bitidx_q, bitidx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic                      deliver;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (baud_clk),
    .rst_ni(rst_n),
    .d_i   (uart_rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    ferr_d   = 1'b0;
    deliver  = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        // Mid-start-bit check: a line already back high was a glitch.
        if (cnt_q == C_HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = DATA;
            bitidx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d            = '0;
          shreg_d[bitidx_q] = rx_s;
          if (bitidx_q == C_LAST_BIT) begin
            state_d = STOP;
          end else begin
            bitidx_d = bitidx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d = '0;
          // A low stop bit parks in WAIT_IDLE so a held break never retriggers.
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    // An ack on the delivery edge frees the slot, so the new byte replaces the old one.
    if (deliver) begin
      if (!valid_q || rx_ack) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ==== tb_uart_rx_8n1 : directed bench with event-timed reference model (rev 1.0) ====
module tb_uart_rx_8n1;

  localparam int N       = 16;
  localparam int H       = N / 2;
  localparam int STOP_OF = 2 + H + 9 * N;

  logic       baud_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       uart_rx  = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  uart_rx_8n1 #(.OVERSAMPLE(N)) dut (
    .baud_clk    (baud_clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_busy     (rx_busy)
  );

  always #5 baud_clk = ~baud_clk;

  typedef struct {
    int         at;
    bit         ferr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int s;
    int e;
  } win_t;

  ev_t  evq[$];
  win_t winq[$];

  int edge_n     = 0;
  int n_total    = 0;
  int n_pass     = 0;
  int rise_edge  = -1;
  int ferr_edge  = -1;
  int ferr_count = 0;

  logic [7:0] e_d  = '0;
  logic       e_v  = 1'b0;
  logic       e_ov = 1'b0;
  logic       e_fe = 1'b0;
  logic       e_b  = 1'b0;
  logic       prev_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, edge_n);
  endtask

  // Reference: frame outcomes are scheduled by the sender at fixed edge offsets;
  // at each edge the handshake rules are applied to the scheduled outcome.
  always begin
    ev_t ev;
    bit  dlv;
    @(posedge baud_clk);
    edge_n++;
    dlv = 1'b0;
    if (!rst_n) begin
      e_d = '0; e_v = 1'b0; e_ov = 1'b0; e_fe = 1'b0;
      evq.delete();
      winq.delete();
    end else begin
      e_fe = 1'b0;
      if (evq.size() > 0 && evq[0].at == edge_n) begin
        ev = evq.pop_front();
        if (ev.ferr) e_fe = 1'b1;
        else dlv = 1'b1;
      end
      if (dlv) begin
        if (!e_v || rx_ack) begin
          e_d = ev.data; e_v = 1'b1; e_ov = 1'b0;
        end else begin
          e_ov = 1'b1;
        end
      end else if (e_v && rx_ack) begin
        e_v = 1'b0; e_ov = 1'b0;
      end
    end
    e_b = 1'b0;
    foreach (winq[i]) if (edge_n >= winq[i].s && edge_n < winq[i].e) e_b = 1'b1;
    while (winq.size() > 0 && winq[0].e <= edge_n) void'(winq.pop_front());

    #2;
    chk("outputs{valid,data,ferr,ovr,busy}",
        {20'd0, rx_valid, rx_data, rx_frame_err, rx_overrun, rx_busy},
        {20'd0, e_v, e_d, e_fe, e_ov, e_b});
    if (rx_valid && !prev_v) rise_edge = edge_n;
    if (rx_frame_err) begin
      ferr_edge = edge_n;
      ferr_count++;
    end
    prev_v = rx_valid;
  end

  // Drives one frame, cycle c of the frame being sampled at edge E0+c.
  task automatic send(input logic [7:0] b, input bit stopv, input bit ack_stop,
                      input int ncyc, output int e0);
    logic [9:0] fb;
    fb = {stopv, b, 1'b0};
    e0 = edge_n + 1;
    evq.push_back('{e0 + STOP_OF, !stopv, b});
    winq.push_back('{e0 + 2, e0 + STOP_OF});
    for (int c = 0; c < ncyc; c++) begin
      uart_rx = fb[c / N];
      if (ack_stop) rx_ack = (c == STOP_OF);
      @(negedge baud_clk);
    end
    rx_ack = 1'b0;
  endtask

  task automatic idle_cycles(input logic lvl, input int n);
    uart_rx = lvl;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge baud_clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge baud_clk);
    chk("reset_outputs", {27'd0, rx_valid, rx_frame_err, rx_overrun, rx_busy, |rx_data}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(1'b1, 2 * N);

    // Nominal 0xA5: valid must rise exactly 154 edges after E0.
    send(8'hA5, 1'b1, 1'b0, 10 * N, e0);
    chk("nominal_rise_edge", rise_edge, e0 + 154);
    chk("nominal_data", rx_data, 8'hA5);
    chk("nominal_valid", rx_valid, 1'b1);
    chk("nominal_no_ferr", ferr_count, 0);
    ack_pulse();
    chk("ack_clears_valid", rx_valid, 1'b0);
    idle_cycles(1'b1, N);

    // Four-cycle low glitch: START window only, no byte.
    e0 = edge_n + 1;
    winq.push_back('{e0 + 2, e0 + 2 + H});
    idle_cycles(1'b0, 4);
    idle_cycles(1'b1, 3 * N);
    chk("glitch_no_valid", rx_valid, 1'b0);
    chk("glitch_idle", rx_busy, 1'b0);

    // Framing error followed by a 40-bit break.
    send(8'h3C, 1'b0, 1'b0, 10 * N, e0);
    idle_cycles(1'b0, 40 * N);
    chk("ferr_edge", ferr_edge, e0 + 154);
    chk("ferr_single_pulse", ferr_count, 1);
    chk("ferr_data_kept", rx_data, 8'hA5);
    chk("break_no_valid", rx_valid, 1'b0);
    idle_cycles(1'b1, 2 * N);
    send(8'h81, 1'b1, 1'b0, 10 * N, e0);
    chk("after_break_data", rx_data, 8'h81);
    chk("after_break_valid", rx_valid, 1'b1);
    ack_pulse();
    idle_cycles(1'b1, N);

    // Overrun: two back-to-back frames without ack.
    send(8'h11, 1'b1, 1'b0, 10 * N, e0);
    send(8'h22, 1'b1, 1'b0, 10 * N, e0);
    chk("overrun_data_kept", rx_data, 8'h11);
    chk("overrun_flag", rx_overrun, 1'b1);
    ack_pulse();
    chk("overrun_ack_clear", {rx_valid, rx_overrun}, 2'b00);
    idle_cycles(1'b1, N);

    // Ack lands on the stop-sample edge of the second frame.
    send(8'h11, 1'b1, 1'b0, 10 * N, e0);
    send(8'h22, 1'b1, 1'b1, 10 * N, e0);
    chk("same_edge_data", rx_data, 8'h22);
    chk("same_edge_flags", {rx_valid, rx_overrun}, 2'b10);
    ack_pulse();
    idle_cycles(1'b1, N);

    // Reset in the middle of data bit 4 of 0xF0, line low across release.
    send(8'hF0, 1'b1, 1'b0, 5 * N + H, e0);
    rst_n   = 1'b0;
    uart_rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    chk("midreset_outputs", {rx_valid, rx_frame_err, rx_overrun, rx_busy, rx_data}, 12'd0);
    rst_n = 1'b1;
    // Synchronizer reset-high makes the low line look like a short low pulse.
    e0 = edge_n + 1;
    winq.push_back('{e0 + 2, e0 + 2 + H});
    idle_cycles(1'b0, 2);
    idle_cycles(1'b1, 2 * N);
    chk("midreset_no_byte", {rx_valid, rx_frame_err}, 2'b00);
    send(8'h5A, 1'b1, 1'b0, 10 * N, e0);
    chk("post_reset_data", rx_data, 8'h5A);
    chk("post_reset_valid", rx_valid, 1'b1);
    idle_cycles(1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
